// File: rtl/iir_coef_loader.sv
// rtl/iir_coef_loader.sv - shadow/active coefficient bank and sample-rate enable for the biquad iir
module iir_coef_loader #(
    parameter int CW         = 32,
    parameter int SAMPLE_DIV = 80,
    parameter int CNT_W      = 7
) (
    input  logic          clk_fast,
    input  logic          rst_b,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [2:0]    wr_idx,
    input  logic [CW-1:0] wr_data,
    input  logic          commit,
    output logic          busy,
    output logic          commit_done,
    output logic          wr_err,
    output logic          sample_en,
    output logic [CW-1:0] b0,
    output logic [CW-1:0] b1,
    output logic [CW-1:0] b2,
    output logic [CW-1:0] a1,
    output logic [CW-1:0] a2
);

    localparam logic [CW-1:0]    COEF_ONE = CW'(32'h3F800000);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    sh_b0, sh_b1, sh_b2, sh_a1, sh_a2;
    logic             accept;
    logic             idx_ok;
    logic             apply;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == PENDING);
    assign accept   = wr_valid & wr_ready;
    assign idx_ok   = (wr_idx <= 3'd4);
    // sample_en is the registered boundary pulse, so the copy lands on the same edge the filter advances
    assign apply    = busy & sample_en;

    always_ff @(posedge clk_fast or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit)    state_nxt = PENDING;
            PENDING: if (sample_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_b) begin
        if (!rst_b) begin
            cnt       <= '0;
            sample_en <= 1'b0;
        end else begin
            cnt       <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            sample_en <= (cnt == CNT_MAX);
        end
    end

    always_ff @(posedge clk_fast or negedge rst_b) begin
        if (!rst_b) begin
            sh_b0  <= COEF_ONE;
            sh_b1  <= '0;
            sh_b2  <= '0;
            sh_a1  <= '0;
            sh_a2  <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= accept & ~idx_ok;
            if (accept) begin
                case (wr_idx)
                    3'd0:    sh_b0 <= wr_data;
                    3'd1:    sh_b1 <= wr_data;
                    3'd2:    sh_b2 <= wr_data;
                    3'd3:    sh_a1 <= wr_data;
                    3'd4:    sh_a2 <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_b) begin
        if (!rst_b) begin
            b0          <= COEF_ONE;
            b1          <= '0;
            b2          <= '0;
            a1          <= '0;
            a2          <= '0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= apply;
            if (apply) begin
                b0 <= sh_b0;
                b1 <= sh_b1;
                b2 <= sh_b2;
                a1 <= sh_a1;
                a2 <= sh_a2;
            end
        end
    end

endmodule

// File: tb/tb_iir_coef_loader.sv
// tb/tb_iir_coef_loader.sv - randomized bench with a behavioural bank/commit model for iir_coef_loader
module tb_iir_coef_loader;

    localparam int DIV = 80;

    logic        clk_fast = 1'b0;
    logic        rst_b = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_idx = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic        commit = 1'b0;
    logic        busy, commit_done, wr_err, sample_en;
    logic [31:0] b0, b1, b2, a1, a2;

    iir_coef_loader #(.CW(32), .SAMPLE_DIV(DIV), .CNT_W(7)) dut (
        .clk_fast(clk_fast), .rst_b(rst_b),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .commit(commit), .busy(busy), .commit_done(commit_done), .wr_err(wr_err),
        .sample_en(sample_en), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2)
    );

    always #5 clk_fast = ~clk_fast;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: edges since reset release, a pending flag and two coefficient banks
    int          m_tick;
    bit          m_pend;
    logic [31:0] m_sh [5];
    logic [31:0] m_act [5];
    bit          m_se, m_cd, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tick = 0;
        m_pend = 1'b0;
        m_se = 1'b0;
        m_cd = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_sh[i]  = (i == 0) ? 32'h3F800000 : 32'h0;
            m_act[i] = (i == 0) ? 32'h3F800000 : 32'h0;
        end
    endtask

    // Advances the model over the coming rising edge using the inputs now applied
    task automatic model_step();
        if (!rst_b) begin
            model_reset();
        end else begin
            m_tick++;
            m_cd  = 1'b0;
            m_err = 1'b0;
            if (m_pend) begin
                if (m_se) begin
                    m_act  = m_sh;
                    m_pend = 1'b0;
                    m_cd   = 1'b1;
                end
            end else begin
                if (wr_valid) begin
                    if (wr_idx < 3'd5) m_sh[wr_idx] = wr_data;
                    else               m_err = 1'b1;
                end
                if (commit) m_pend = 1'b1;
            end
            m_se = (m_tick % DIV == 0);
        end
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk_fast);
    endtask

    initial begin
        forever begin
            @(posedge clk_fast);
            #1;
            if (chk_en) begin
                chk("wr_ready", {31'd0, wr_ready}, {31'd0, ~m_pend});
                chk("busy", {31'd0, busy}, {31'd0, m_pend});
                chk("sample_en", {31'd0, sample_en}, {31'd0, m_se});
                chk("commit_done", {31'd0, commit_done}, {31'd0, m_cd});
                chk("wr_err", {31'd0, wr_err}, {31'd0, m_err});
                chk("b0", b0, m_act[0]);
                chk("b1", b1, m_act[1]);
                chk("b2", b2, m_act[2]);
                chk("a1", a1, m_act[3]);
                chk("a2", a2, m_act[4]);
            end
        end
    end

    task automatic do_reset();
        rst_b = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_b = 1'b1;
    endtask

    task automatic write(input logic [2:0] idx, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (!busy) break;
            n++;
            cycle();
        end
    endtask

    int n;
    int first_se;
    int second_se;
    logic [31:0] d;

    initial begin
        model_reset();
        @(negedge clk_fast);
        chk_en = 1'b1;
        do_reset();
        chk("reset_b0", b0, 32'h3F800000);
        chk("reset_a2", a2, 32'h0);
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 1: sample_en phase after release
        first_se = 0;
        second_se = 0;
        for (int k = 1; k <= 2 * DIV + 5; k++) begin
            cycle();
            if (sample_en && first_se == 0)      first_se = k;
            else if (sample_en && second_se == 0) second_se = k;
        end
        chk("first_sample_en", first_se, 80);
        chk("sample_period", second_se - first_se, 80);

        // 2: commit at cnt=10 waits 70 cycles
        do_reset();
        write(3'd0, 32'h3F000000);
        write(3'd3, 32'hBF000000);
        repeat (8) cycle();
        pulse_commit();
        count_busy(n);
        chk("busy_len_cnt10", n, 70);
        chk("commit_done_after", {31'd0, commit_done}, 32'd1);
        chk("b0_new", b0, 32'h3F000000);
        chk("a1_new", a1, 32'hBF000000);
        chk("b1_kept", b1, 32'h0);

        // 3: write held during PENDING stalls until IDLE and joins the next commit
        pulse_commit();
        d = $urandom;
        wr_valid = 1'b1;
        wr_idx   = 3'd2;
        wr_data  = d;
        n = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (wr_ready) n = 1;
            cycle();
            if (n == 1) break;
        end
        wr_valid = 1'b0;
        chk("stalled_write_accepted", n, 1);
        chk("b2_not_yet", b2, 32'h0);
        pulse_commit();
        count_busy(n);
        chk("b2_after_commit", b2, d);

        // 4: commit coincident with sample_en waits a full period
        n = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (sample_en) break;
            cycle();
        end
        chk("se_found", {31'd0, sample_en}, 32'd1);
        pulse_commit();
        count_busy(n);
        chk("busy_len_on_se", n, 80);

        // 5: invalid index
        write(3'd6, 32'hDEADBEEF);
        chk("wr_err_pulse", {31'd0, wr_err}, 32'd1);
        pulse_commit();
        count_busy(n);
        chk("b2_after_bad", b2, d);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_idx   = 3'($urandom_range(0, 7));
            wr_data  = $urandom;
            commit   = ($urandom_range(0, 40) == 0);
            cycle();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;

        // 6: reset while PENDING
        pulse_commit();
        cycle();
        chk("pending_before_reset", {31'd0, busy}, 32'd1);
        rst_b = 1'b0;
        model_reset();
        #1;
        chk("reset_busy_now", {31'd0, busy}, 32'd0);
        chk("reset_b0_now", b0, 32'h3F800000);
        chk("reset_b2_now", b2, 32'h0);
        chk("reset_no_done", {31'd0, commit_done}, 32'd0);
        @(negedge clk_fast);
        cycle();
        rst_b = 1'b1;
        repeat (DIV + 5) cycle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
